// File: rtl/dbus_periph_resp.sv
`default_nettype none
// ============================================================================
// Module   : dbus_periph_resp
// Summary  : Tagged, in-order register responder on the core data bus. A
//            request FIFO feeds the ID, scratch, 64-bit timer, compare/IRQ and
//            GPIO registers. Each request gets exactly one tagged response.
// Options  : PERIPH_TIMER_PRESCALE_EN adds PRESCALE at offset 0x1C.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_periph_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          REQ_DEPTH = 4,
  parameter logic [31:0] PERIPH_ID = 32'hC0DE_0001,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dbus_addr_i,
  input  logic [31:0]       dbus_wdata_i,
  input  logic              dbus_ren_i,
  input  logic [3:0]        dbus_wen_i,
  input  logic [10:0]       dbus_req_tag_i,
  output logic              dbus_accept_o,
  output logic              dbus_ack_o,
  output logic              dbus_error_o,
  output logic [31:0]       dbus_rdata_o,
  output logic [10:0]       dbus_resp_tag_o,
  output logic              irq_o,
  output logic [GPIO_W-1:0] gpio_o
);

  localparam int                 c_ptr_w   = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int                 c_ent_w   = 30 + 32 + 1 + 4 + 11;
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(REQ_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);

  // Word offsets inside the 4 KB window
  localparam logic [9:0] c_off_id       = 10'h000;
  localparam logic [9:0] c_off_scratch  = 10'h001;
  localparam logic [9:0] c_off_timer_lo = 10'h002;
  localparam logic [9:0] c_off_timer_hi = 10'h003;
  localparam logic [9:0] c_off_cmp      = 10'h004;
  localparam logic [9:0] c_off_ctrl     = 10'h005;
  localparam logic [9:0] c_off_gpio     = 10'h006;
`ifdef PERIPH_TIMER_PRESCALE_EN
  localparam logic [9:0] c_off_prescale = 10'h007;
`endif

  // Request FIFO
  logic [c_ent_w-1:0] r_fifo_mem [REQ_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic               w_req;
  logic               w_push;
  logic               w_pop;
  logic               w_unused;

  logic [29:0]        w_h_addr;
  logic [31:0]        w_h_wdata;
  logic               w_h_ren;
  logic [3:0]         w_h_wen;
  logic [10:0]        w_h_tag;
  logic               w_h_wr;
  logic               w_in_win;
  logic [9:0]         w_off;
  logic [31:0]        w_mask;

  // Register block
  logic [31:0]        r_scratch;
  logic [31:0]        r_cmp;
  logic [31:0]        r_shadow;
  logic [63:0]        r_timer;
  logic [GPIO_W-1:0]  r_gpio;
  logic               r_ie;
  logic               r_pend;
  logic               r_irq;

  // Response
  logic               r_ack;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [10:0]        r_tag;

  // Execute-stage decode results
  logic               w_err;
  logic [31:0]        w_rdata;
  logic               w_we_scratch;
  logic               w_we_cmp;
  logic               w_we_ctrl;
  logic               w_we_gpio;
  logic               w_snap;
  logic               w_tick;
  logic               w_match;
  logic               w_w1c;
  logic               w_ie_nxt;
  logic               w_pend_nxt;

`ifdef PERIPH_TIMER_PRESCALE_EN
  logic [15:0]        r_prescale;
  logic [15:0]        r_pre_cnt;
  logic               w_we_pre;
`endif

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
    f_merge = (old_val & ~mask) | (new_val & mask);
  endfunction

  // Byte lane [1:0] of the address never reaches the register block
  assign w_unused = ^dbus_addr_i[1:0];

  assign w_req         = dbus_ren_i | (|dbus_wen_i);
  assign dbus_accept_o = (r_count != c_depth);
  assign w_push        = w_req & dbus_accept_o;
  assign w_pop         = (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {dbus_addr_i[31:2], dbus_wdata_i, dbus_ren_i,
                               dbus_wen_i, dbus_req_tag_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign {w_h_addr, w_h_wdata, w_h_ren, w_h_wen, w_h_tag} = r_fifo_mem[r_rd_ptr];
  assign w_h_wr   = |w_h_wen;
  assign w_in_win = (w_h_addr[29:10] == BASE_ADDR[31:12]);
  assign w_off    = w_h_addr[9:0];
  assign w_mask   = {{8{w_h_wen[3]}}, {8{w_h_wen[2]}}, {8{w_h_wen[1]}}, {8{w_h_wen[0]}}};

  always_comb begin
    w_err        = 1'b0;
    w_rdata      = '0;
    w_we_scratch = 1'b0;
    w_we_cmp     = 1'b0;
    w_we_ctrl    = 1'b0;
    w_we_gpio    = 1'b0;
    w_snap       = 1'b0;
`ifdef PERIPH_TIMER_PRESCALE_EN
    w_we_pre     = 1'b0;
`endif
    if (w_pop) begin
      if (!w_in_win || (w_h_ren && w_h_wr)) begin
        w_err = 1'b1;
      end else begin
        case (w_off)
          c_off_id: begin
            if (w_h_ren) w_rdata = PERIPH_ID;
          end
          c_off_scratch: begin
            if (w_h_ren) w_rdata = r_scratch;
            else         w_we_scratch = 1'b1;
          end
          c_off_timer_lo: begin
            if (w_h_ren) begin
              w_rdata = r_timer[31:0];
              w_snap  = 1'b1;
            end
          end
          c_off_timer_hi: begin
            if (w_h_ren) w_rdata = r_shadow;
          end
          c_off_cmp: begin
            if (w_h_ren) w_rdata = r_cmp;
            else         w_we_cmp = 1'b1;
          end
          c_off_ctrl: begin
            if (w_h_ren) w_rdata = {30'd0, r_pend, r_ie};
            else         w_we_ctrl = 1'b1;
          end
          c_off_gpio: begin
            if (w_h_ren) w_rdata = 32'(r_gpio);
            else         w_we_gpio = 1'b1;
          end
`ifdef PERIPH_TIMER_PRESCALE_EN
          c_off_prescale: begin
            if (w_h_ren) w_rdata = {16'd0, r_prescale};
            else         w_we_pre = 1'b1;
          end
`endif
          default: w_err = 1'b1;
        endcase
      end
    end
  end

`ifdef PERIPH_TIMER_PRESCALE_EN
  assign w_tick = (r_pre_cnt == r_prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_pre_cnt  <= '0;
    end else if (w_we_pre) begin
      r_prescale <= (r_prescale & ~w_mask[15:0]) | (w_h_wdata[15:0] & w_mask[15:0]);
      r_pre_cnt  <= '0;
    end else if (w_tick) begin
      r_pre_cnt  <= '0;
    end else begin
      r_pre_cnt  <= r_pre_cnt + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // A compare match in the same cycle as a W1C keeps PEND set
  assign w_match    = (r_timer[31:0] == r_cmp);
  assign w_w1c      = w_we_ctrl & w_h_wen[0] & w_h_wdata[1];
  assign w_ie_nxt   = (w_we_ctrl & w_h_wen[0]) ? w_h_wdata[0] : r_ie;
  assign w_pend_nxt = w_match | (r_pend & ~w_w1c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= r_timer + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= '0;
      r_cmp     <= '0;
      r_shadow  <= '0;
      r_gpio    <= '0;
      r_ie      <= 1'b0;
      r_pend    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_we_scratch) begin
        r_scratch <= f_merge(r_scratch, w_h_wdata, w_mask);
      end
      if (w_we_cmp) begin
        r_cmp <= f_merge(r_cmp, w_h_wdata, w_mask);
      end
      if (w_we_gpio) begin
        r_gpio <= (r_gpio & ~w_mask[GPIO_W-1:0]) | (w_h_wdata[GPIO_W-1:0] & w_mask[GPIO_W-1:0]);
      end
      if (w_snap) begin
        r_shadow <= r_timer[63:32];
      end
      r_ie   <= w_ie_nxt;
      r_pend <= w_pend_nxt;
      r_irq  <= w_ie_nxt & w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_tag   <= '0;
    end else begin
      r_ack   <= w_pop;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_tag   <= w_pop ? w_h_tag : 11'd0;
    end
  end

  assign dbus_ack_o      = r_ack;
  assign dbus_error_o    = r_err;
  assign dbus_rdata_o    = r_rdata;
  assign dbus_resp_tag_o = r_tag;
  assign irq_o           = r_irq;
  assign gpio_o          = r_gpio;

endmodule
`default_nettype wire
